cla_result_serializer: RTL and testbench
========================================

// Module: cla_result_serializer
// PURPOSE
//  Output-side companion to the 4-bit operand input register in front of the CLA adder.
//  - Captures the adder result ({cout, sum}) through a valid/ready handshake.
//  - Double-buffers the result, then shifts it out bit-serially, LSB first, to a downstream consumer.
//  - Sits between the CLA adder output and the serial/monitor port.
// PARAMETERS
//  WIDTH   4   adder sum width; frame length = WIDTH+1 bits (sum LSB first, then cout)
//  CNT_W   8   width of the completed-frame counter
// PORTS
//  clk          in   1        rising-edge clock, single clock domain
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        result present on in_sum/in_cout
//  in_ready     out  1        holding register can accept a result
//  in_sum       in   WIDTH    adder sum
//  in_cout      in   1        adder carry-out
//  ser_valid    out  1        ser_data holds a valid frame bit
//  ser_ready    in   1        downstream accepts the current bit
//  ser_data     out  1        current serial bit
//  ser_last     out  1        current bit is the final (cout) bit of the frame
//  busy         out  1        frame shifting or result held
//  frames_done  out  CNT_W    count of fully transferred frames, wraps
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, takes precedence over everything):
//  - hold_full=0, state=IDLE, shift=0, bit_cnt=0, frames_done=0.
//  - Resulting outputs: in_ready=1, ser_valid=0, ser_data=0, ser_last=0, busy=0.
//  - Reset mid-frame discards both the current and the held result; no partial frame resumes.
//  - in_valid is ignored while rst=1.
//  Input handshake:
//  - in_ready = ~hold_full (registered state, no combinational path from ser_ready).
//  - Accept on an edge where in_valid & in_ready: hold <= {in_cout,in_sum}, hold_full <= 1.
//  FSM, two states:
//  - IDLE: ser_valid=0. If hold_full: shift <= hold, bit_cnt <= 0, hold_full <= 0, go to SHIFT.
//  - SHIFT: ser_valid=1, ser_data=shift[0], ser_last=(bit_cnt==WIDTH).
//  - On an edge with ser_valid & ser_ready & ~ser_last: shift >>= 1, bit_cnt++.
//  - On an edge with ser_valid & ser_ready & ser_last: frames_done++ (mod 2^CNT_W).
//    - If hold_full on that same edge: reload shift from hold, bit_cnt <= 0, hold_full <= 0,
//      stay in SHIFT (gapless back-to-back frames).
//    - Otherwise go to IDLE.
//  - ser_ready=0: shift, bit_cnt, ser_data and ser_last hold stable (no drop, no repeat).
//  Latency: accept at edge N -> hold_full at N -> shift loaded at N+1 -> first bit valid
//   from N+1 until taken. Minimum frame time WIDTH+1 cycles.
//  Simultaneous events:
//  - A new accept cannot coincide with hold->shift transfer, because in_ready is low while hold_full.
//  - hold frees on the transfer edge, so in_ready rises the cycle after a load.
//  busy = (state==SHIFT) | hold_full.
//  Width rule: frame is exactly WIDTH+1 bits; bit_cnt is clog2(WIDTH+1) bits and never exceeds WIDTH.
// STRUCTURE
//  - cla_defs.vh: default WIDTH, state encodings ST_IDLE/ST_SHIFT; shared with the adder and the
//    input register.
//  - Sub-module cla_result_hold: WIDTH+1 bit holding register with full flag, load and take strobes.
//  - Top: FSM, shift register, bit counter, frame counter.
// TESTING  (WIDTH=4, CNT_W=8)
//  1. Assert rst 2 cycles -> in_ready=1, ser_valid=0, busy=0, frames_done=0.
//  2. Send sum=4'b1011, cout=1, ser_ready=1 -> first ser_valid 1 cycle after accept;
//     ser_data 1,1,0,1,1; ser_last on 5th bit only; frames_done=1.
//  3. Send 4'h5/c0 then 4'hA/c1 back-to-back -> 10 contiguous bits 1,0,1,0,0,0,1,0,1,1;
//     no idle gap; in_ready=0 while second result is held.
//  4. ser_ready=0 for 3 cycles after bit 2 of 4'b0110/c0 -> ser_data stays 1 and bit_cnt frozen;
//     frame completes as 0,1,1,0,0.
//  5. rst for 1 cycle after bit 1 with a second result held -> next cycle ser_valid=0, in_ready=1,
//     frames_done=0; a new 4'hF/c1 then emits 1,1,1,1,1.
//  6. 256 frames -> frames_done wraps 255 -> 0; no bit lost (scoreboard compare).

Source files
------------

// File: rtl/cla_result_serializer_pkg.sv
// Shared definitions for the CLA result serializer: default widths and FSM states.
package cla_result_serializer_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/cla_result_hold.sv
// Single-entry holding register with full flag. Load and take are mutually
// exclusive by construction upstream (load only when empty, take only when full).
module cla_result_hold #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    // Capture a new result on load, free the entry on take.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cla_result_serializer.sv
// Captures {cout,sum} from the CLA adder, double-buffers it and shifts it out
// LSB first as a WIDTH+1 bit frame over a valid/ready serial port.
module cla_result_serializer
    import cla_result_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] frames_done
);

    localparam int FW  = WIDTH + 1;
    localparam int BCW = $clog2(WIDTH + 1);

    ser_state_e     state;
    logic [FW-1:0]  shift;
    logic [BCW-1:0] bit_cnt;
    logic [FW-1:0]  hold_data;
    logic           hold_full;
    logic           hold_load;
    logic           hold_take;
    logic           fire;

    // Outputs derive only from registered state; ser_ready never reaches in_ready.
    assign in_ready  = ~hold_full;
    assign ser_valid = (state == ST_SHIFT);
    assign ser_data  = (state == ST_SHIFT) & shift[0];
    assign ser_last  = (state == ST_SHIFT) & (bit_cnt == BCW'(WIDTH));
    assign busy      = (state == ST_SHIFT) | hold_full;
    assign fire      = ser_valid & ser_ready;

    // Hold empties whenever the shifter pulls from it: on an idle cycle, or on
    // the last-bit edge of the current frame for gapless back-to-back frames.
    assign hold_load = in_valid & ~hold_full;
    assign hold_take = hold_full & ((state == ST_IDLE) | (fire & ser_last));

    cla_result_hold #(.W(FW)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (hold_load),
        .take (hold_take),
        .din  ({in_cout, in_sum}),
        .dout (hold_data),
        .full (hold_full)
    );

    // Frame FSM: shift register, bit counter and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            frames_done <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        shift   <= hold_data;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        if (!ser_last) begin
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + BCW'(1);
                        end else begin
                            frames_done <= frames_done + CNT_W'(1);
                            if (hold_full) begin
                                shift   <= hold_data;
                                bit_cnt <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_result_serializer.sv
// Directed bench for cla_result_serializer (WIDTH=4, CNT_W=8). A negedge monitor
// records every accepted serial bit; frames are checked against hand values.
module tb_cla_result_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sum;
    logic       in_cout;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_data;
    logic       ser_last;
    logic       busy;
    logic [7:0] frames_done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic q_data[$];
    logic q_last[$];
    int   q_cyc[$];
    logic [4:0] exp_q[$];
    logic [4:0] t6_v;
    logic [7:0] prev_fd = 8'd0;
    logic       saw_wrap = 1'b0;

    cla_result_serializer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_cout     (in_cout),
        .ser_valid   (ser_valid),
        .ser_ready   (ser_ready),
        .ser_data    (ser_data),
        .ser_last    (ser_last),
        .busy        (busy),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record each bit that will be taken at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && ser_valid && ser_ready) begin
            q_data.push_back(ser_data);
            q_last.push_back(ser_last);
            q_cyc.push_back(cyc);
        end
        if (!rst && prev_fd == 8'd255 && frames_done == 8'd0) saw_wrap = 1'b1;
        prev_fd = frames_done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Present one result and hold in_valid until it is accepted.
    task automatic send(input logic [3:0] s, input logic c);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sum   = s;
        in_cout  = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    function automatic logic [4:0] frame_data(input int base);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = q_data[base + i];
        return r;
    endfunction

    function automatic logic [4:0] frame_last(input int base);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = q_last[base + i];
        return r;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] two;
        logic [9:0] two_last;
        in_valid  = 1'b0;
        in_sum    = 4'h0;
        in_cout   = 1'b0;
        ser_ready = 1'b1;

        // 1. reset state
        do_reset(2);
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_ser_valid", 32'(ser_valid),   32'd0);
        chk("rst_ser_data",  32'(ser_data),    32'd0);
        chk("rst_ser_last",  32'(ser_last),    32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_frames",    32'(frames_done), 32'd0);

        // 2. single frame 1011/c1 -> bits 1,1,0,1,1
        clear_q();
        send(4'b1011, 1'b1);
        chk("t2_valid_at_accept", 32'(ser_valid), 32'd0);
        chk("t2_in_ready_held",   32'(in_ready),  32'd0);
        chk("t2_busy_held",       32'(busy),      32'd1);
        @(posedge clk); #1;
        chk("t2_valid_next",      32'(ser_valid), 32'd1);
        chk("t2_first_bit",       32'(ser_data),  32'd1);
        chk("t2_in_ready_free",   32'(in_ready),  32'd1);
        wait_bits(5);
        chk("t2_nbits",   32'(q_data.size()), 32'd5);
        chk("t2_bits",    32'(frame_data(0)), 32'h1B);
        chk("t2_last",    32'(frame_last(0)), 32'h10);
        chk("t2_frames",  32'(frames_done),   32'd1);
        chk("t2_idle",    32'(ser_valid),     32'd0);

        // 3. back-to-back 5/c0 then A/c1, 10 contiguous bits
        clear_q();
        send(4'h5, 1'b0);
        send(4'hA, 1'b1);
        chk("t3_in_ready_held", 32'(in_ready), 32'd0);
        wait_bits(10);
        chk("t3_nbits", 32'(q_data.size()), 32'd10);
        if (q_data.size() >= 10) begin
            two      = {frame_data(5), frame_data(0)};
            two_last = {frame_last(5), frame_last(0)};
            chk("t3_bits", 32'(two),      32'h345);
            chk("t3_last", 32'(two_last), 32'h210);
            chk("t3_gapless", 32'(q_cyc[9] - q_cyc[0]), 32'd9);
        end
        chk("t3_frames", 32'(frames_done), 32'd3);

        // 4. stall 3 cycles with bit 2 of 0110/c0 on the wire
        clear_q();
        send(4'b0110, 1'b0);
        wait_bits(2);
        ser_ready = 1'b0;
        chk("t4_stall_data", 32'(ser_data), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_hold_data",  32'(ser_data),    32'd1);
            chk("t4_hold_valid", 32'(ser_valid),   32'd1);
            chk("t4_hold_last",  32'(ser_last),    32'd0);
            chk("t4_hold_cnt",   32'(dut.bit_cnt), 32'd2);
        end
        ser_ready = 1'b1;
        wait_bits(5);
        chk("t4_nbits", 32'(q_data.size()), 32'd5);
        chk("t4_bits",  32'(frame_data(0)), 32'h06);
        chk("t4_last",  32'(frame_last(0)), 32'h10);
        chk("t4_frames", 32'(frames_done),  32'd4);

        // 5. reset mid-frame with a second result held
        clear_q();
        send(4'h3, 1'b0);
        send(4'h9, 1'b1);
        wait_bits(1);
        chk("t5_held", 32'(in_ready), 32'd0);
        do_reset(1);
        chk("t5_valid",    32'(ser_valid),   32'd0);
        chk("t5_in_ready", 32'(in_ready),    32'd1);
        chk("t5_frames",   32'(frames_done), 32'd0);
        chk("t5_busy",     32'(busy),        32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t5_no_resume", 32'(ser_valid), 32'd0);
        clear_q();
        send(4'hF, 1'b1);
        wait_bits(5);
        chk("t5_nbits",  32'(q_data.size()), 32'd5);
        chk("t5_bits",   32'(frame_data(0)), 32'h1F);
        chk("t5_frames2", 32'(frames_done),  32'd1);

        // 6. 256 frames with random backpressure, counter wraps 255 -> 0
        do_reset(1);
        clear_q();
        exp_q.delete();
        fork
            begin
                for (int k = 0; k < 256; k++) begin
                    t6_v = 5'($urandom_range(0, 31));
                    exp_q.push_back(t6_v);
                    send(t6_v[3:0], t6_v[4]);
                end
            end
            begin
                int t;
                t = 0;
                while (q_data.size() < 1280 && t < 20000) begin
                    @(posedge clk); #1;
                    ser_ready = ($urandom_range(0, 3) != 0);
                    t++;
                end
                ser_ready = 1'b1;
            end
        join
        @(posedge clk); #1;
        chk("t6_nbits", 32'(q_data.size()), 32'd1280);
        if (q_data.size() >= 1280) begin
            for (int k = 0; k < 256; k++) begin
                chk($sformatf("t6_frame%0d", k), 32'(frame_data(k * 5)), 32'(exp_q[k]));
                chk($sformatf("t6_last%0d", k),  32'(frame_last(k * 5)), 32'h10);
            end
        end
        chk("t6_frames_wrapped", 32'(frames_done), 32'd0);
        chk("t6_saw_wrap",       32'(saw_wrap),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
